// File: rtl/skinny_sbox_layer_dom1_serial.sv
// Byte-serial first-order DOM-masked SKINNY 8-bit S-box layer over a 128-bit two-share state.
// Optional: define SKINNY_SHARE_CLEAR_EN to wipe shares and refresh r_q on the output handshake.

module skinny_sbox8_dom1_non_pipelined #(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] si0,
  input  logic [7:0] si1,
  input  logic [7:0] r,
  output logic [7:0] so0,
  output logic [7:0] so1
);

  function automatic logic [7:0] perm(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  function automatic logic [7:0] swap12(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  logic [7:0] x0 [5];
  logic [7:0] x1 [5];

  assign x0[0] = si0;
  assign x1[0] = si1;

  // Each round: two NOR gates (bits 7|6 -> 4, 3|2 -> 0) as DOM ANDs of inverted inputs.
  // Rounds are registered while the next capture is still ahead, so the core settles in
  // exactly SBOX_LAT cycles; the layer's capture register closes the last round.
  for (genvar k = 0; k < 4; k++) begin : g_round
    logic [1:0] u0, u1, v0, v1, rb;
    logic [1:0] in0, in1, cr0, cr1;
    logic [1:0] z0, z1;
    logic [7:0] m0, m1;

    assign u0  = ~{x0[k][7], x0[k][3]};
    assign u1  = {x1[k][7], x1[k][3]};
    assign v0  = ~{x0[k][6], x0[k][2]};
    assign v1  = {x1[k][6], x1[k][2]};
    assign rb  = r[2*k +: 2];
    assign in0 = u0 & v0;
    assign in1 = u1 & v1;
    assign cr0 = (u0 & v1) ^ rb;
    assign cr1 = (u1 & v0) ^ rb;

    if (k + 1 < SBOX_LAT) begin : g_reg
      logic [1:0] in0_q, in1_q, cr0_q, cr1_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          in0_q <= '0;
          in1_q <= '0;
          cr0_q <= '0;
          cr1_q <= '0;
        end else begin
          in0_q <= in0;
          in1_q <= in1;
          cr0_q <= cr0;
          cr1_q <= cr1;
        end
      end
      assign z0 = in0_q ^ cr0_q;
      assign z1 = in1_q ^ cr1_q;
    end else begin : g_comb
      assign z0 = in0 ^ cr0;
      assign z1 = in1 ^ cr1;
    end

    assign m0 = x0[k] ^ {3'b000, z0[1], 3'b000, z0[0]};
    assign m1 = x1[k] ^ {3'b000, z1[1], 3'b000, z1[0]};

    if (k < 3) begin : g_perm
      assign x0[k+1] = perm(m0);
      assign x1[k+1] = perm(m1);
    end else begin : g_swap
      assign x0[k+1] = swap12(m0);
      assign x1[k+1] = swap12(m1);
    end
  end

  assign so0 = x0[4];
  assign so1 = x1[4];

endmodule

module skinny_sbox_layer_dom1_serial #(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] s0_in,
  input  logic [127:0] s1_in,
  input  logic [7:0]   rnd,
  output logic         rnd_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] s0_out,
  output logic [127:0] s1_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] LatLast = 4'(SBOX_LAT - 1);

  state_e       state_q, state_d;
  logic [127:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [7:0]   r_q, r_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]   lat_cnt_q, lat_cnt_d;
  logic [7:0]   so0, so1;

  skinny_sbox8_dom1_non_pipelined #(
    .SBOX_LAT(SBOX_LAT)
  ) u_sbox (
    .clk(clk),
    .rst(rst),
    .si0(sh0_q[127:120]),
    .si1(sh1_q[127:120]),
    .r  (r_q),
    .so0(so0),
    .so1(so1)
  );

  always_comb begin
    state_d    = state_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    r_d        = r_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rnd_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh0_d      = s0_in;
          sh1_d      = s1_in;
          r_d        = rnd;
          rnd_req    = 1'b1;
          byte_cnt_d = '0;
          lat_cnt_d  = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LatLast) begin
          // Rotate left by a byte: after 16 captures the cell order is restored.
          sh0_d     = {sh0_q[119:0], so0};
          sh1_d     = {sh1_q[119:0], so1};
          lat_cnt_d = '0;
          if (byte_cnt_q == 4'd15) begin
            state_d = StDone;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            r_d        = rnd;
            rnd_req    = 1'b1;
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
`ifdef SKINNY_SHARE_CLEAR_EN
          sh0_d   = '0;
          sh1_d   = '0;
          r_d     = rnd;
          rnd_req = 1'b1;
`else
          sh0_d   = sh0_q;
          sh1_d   = sh1_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sh0_q      <= '0;
      sh1_q      <= '0;
      r_q        <= '0;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      r_q        <= r_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  // Gated so intermediate shares never leave the block.
  assign s0_out = out_valid ? sh0_q : '0;
  assign s1_out = out_valid ? sh1_q : '0;

endmodule

// File: tb/tb_skinny_sbox_layer_dom1_serial.sv
// Scoreboard bench for skinny_sbox_layer_dom1_serial: directed masked vectors, timing,
// backpressure and mid-run reset; expected S-box values are hand-computed table entries.

module tb_skinny_sbox_layer_dom1_serial;

  localparam int unsigned Lat = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, rnd_req, out_valid;
  logic [127:0] s0_in = '0;
  logic [127:0] s1_in = '0;
  logic [127:0] s0_out, s1_out;
  logic [7:0]   rnd = '0;

  int n_tests = 0;
  int n_fail = 0;
  int rnd_cnt = 0;
  int rnd_base = 0;

  typedef struct packed {
    logic [127:0] exp;
    logic         chk_sh;
  } exp_t;

  exp_t sb_q[$];

  skinny_sbox_layer_dom1_serial #(
    .SBOX_LAT(Lat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s0_in    (s0_in),
    .s1_in    (s1_in),
    .rnd      (rnd),
    .rnd_req  (rnd_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s0_out   (s0_out),
    .s1_out   (s1_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    rnd = 8'($urandom);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: counts randomness requests, checks output gating and pops on each handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rnd_req) rnd_cnt++;
    if (!rst) begin
      if (!out_valid) begin
        check("gate_zero", s0_out | s1_out, '0);
      end else if (out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got xor %h want no output", s0_out ^ s1_out);
        end else begin
          e = sb_q.pop_front();
          check("xor_result", s0_out ^ s1_out, e.exp);
          if (e.chk_sh) begin
            n_tests++;
            if (s0_out === e.exp || s1_out === e.exp) begin
              n_fail++;
              $display("FAIL share_masked: got s0 %h s1 %h want neither %h", s0_out, s1_out,
                       e.exp);
            end
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns one cycle after the accepting edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] mask,
                      input logic [127:0] exp, input logic chk_sh, input logic push);
    int n = 0;
    s0_in    = pt ^ mask;
    s1_in    = mask;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'd1);
    rnd_base = rnd_cnt;
    if (push) sb_q.push_back('{exp: exp, chk_sh: chk_sh});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ExpZero  = {16{8'h65}};
  localparam logic [127:0] PtOrder  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ExpOrder = 128'h654c6a424b63436b55755a7a53735b7b;
  localparam logic [127:0] PtRev    = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ExpRev   = 128'h7b5b73537a5a75556b43634b426a4c65;
  localparam logic [127:0] PtOnes   = {16{8'h01}};
  localparam logic [127:0] ExpOnes  = {16{8'h4c}};
  localparam logic [127:0] MaskA    = 128'h3c5a96e10f7bd248a5c31e6987f02bd4;
  localparam logic [127:0] MaskB    = 128'h9e3779b97f4a7c15f39cc0605cedc834;

  initial begin
    int k;
    logic ir_bad;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_valid_req", 128'({in_ready, out_valid, rnd_req}), 128'(3'b100));
    check("rst_outputs", s0_out | s1_out, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero state with latency, in_ready and randomness-request accounting.
    send('0, '0, ExpZero, 1'b0, 1'b1);
    k = 1;
    ir_bad = 1'b0;
    while (!out_valid && k < 300) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    check("latency_cycle", 128'(k), 128'(16 * Lat + 1));
    check("in_ready_busy", 128'(ir_bad), '0);
    check("rnd_req_count", 128'(rnd_cnt - rnd_base), 128'd16);
    @(posedge clk);
    #1;

    // Masked all-ones under backpressure, with the next block held at the input.
    out_ready = 1'b0;
    send('1, MaskA, '1, 1'b1, 1'b1);
    k = 0;
    while (!out_valid && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_valid", 128'(out_valid), 128'd1);
    s0_in    = PtOrder ^ MaskB;
    s1_in    = MaskB;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_xor", s0_out ^ s1_out, '1);
      check("bp_no_accept", 128'({out_valid, in_ready}), 128'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after_hs", 128'({out_valid, in_ready}), 128'(2'b01));
    rnd_base = rnd_cnt;
    sb_q.push_back('{exp: ExpOrder, chk_sh: 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", 128'(in_ready), '0);
    wait_done("byte_order");

    // Abort a block at byte 7, then run full blocks.
    send(PtOnes, MaskA, '0, 1'b0, 1'b0);
    repeat (28) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state", 128'({out_valid, in_ready}), 128'(2'b01));
    check("abort_outputs", s0_out | s1_out, '0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_output", 128'(out_valid), '0);

    send(PtRev, MaskB, ExpRev, 1'b0, 1'b1);
    wait_done("reversed");
    send(PtOnes, MaskA ^ MaskB, ExpOnes, 1'b0, 1'b1);
    wait_done("ones");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(sb_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_layer_dom1_serial.md
Name: skinny_sbox_layer_dom1_serial

Overview:
Applies the SKINNY 8-bit S-box to all 16 cells of a first-order masked 128-bit state, one byte at a time. It instantiates one skinny_sbox8_dom1_non_pipelined core and feeds it the two input shares plus fresh randomness per byte. It collects both output shares back into the state. It sits between the round-state register and the AddConstant/ShiftRows stage of the masked SKINNY-128-384+ datapath.

Parameters:
SBOX_LAT, 4, cycles from stable S-box inputs to valid S-box outputs. Integer 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input state shares valid
in_ready  output  1  block idle and able to accept
s0_in  input  128  share 0 of state
s1_in  input  128  share 1 of state
rnd  input  8  fresh randomness, sampled when rnd_req=1
rnd_req  output  1  rnd consumed this cycle
out_valid  output  1  result shares valid, held until out_ready
out_ready  input  1  downstream accepts result
s0_out  output  128  share 0 of S-box layer output
s1_out  output  128  share 1 of S-box layer output

Behaviour:
- Registers: sh0_q and sh1_q (128 bits each), r_q (8 bits), byte_cnt (4 bits), lat_cnt (4 bits), FSM {IDLE, RUN, DONE}.
- Reset (rst=1 at a posedge, from any state): FSM goes to IDLE. All registers clear to 0. Outputs go to in_ready=1, out_valid=0, rnd_req=0, s0_out=s1_out=0.
- S-box core wiring:
  - si0 = sh0_q[127:120], si1 = sh1_q[127:120], r = r_q.
  - Cell 0 is the MSB byte.
- IDLE:
  - in_ready=1.
  - On in_valid=1, the block loads sh0_q<=s0_in, sh1_q<=s1_in and r_q<=rnd, with rnd_req=1 that cycle.
  - It sets byte_cnt=0 and lat_cnt=0, and goes to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, lat_cnt increments.
  - When lat_cnt==SBOX_LAT-1, this is a capture cycle:
    - Shift both shares: sh0_q<={sh0_q[119:0], so0}, sh1_q<={sh1_q[119:0], so1}.
    - Clear lat_cnt to 0.
    - If byte_cnt==15, go to DONE.
    - Otherwise, increment byte_cnt, load r_q<=rnd and assert rnd_req=1.
  - After 16 shifts the output byte order equals the input byte order.
- S-box input timing:
  - S-box inputs are held stable for exactly SBOX_LAT cycles per byte.
  - A new byte is never presented before the previous byte is captured.
- Randomness:
  - rnd_req pulses exactly 16 times per block: once at acceptance, then at the first 15 captures.
  - rnd must be fresh on every pulse. It is not checked.
- DONE:
  - out_valid=1. s0_out=sh0_q, s1_out=sh1_q, held stable.
  - On out_ready=1, go to IDLE and drop out_valid next cycle.
  - in_ready is 0 in DONE, so a new block is accepted no earlier than the cycle after the out handshake.
- s0_out and s1_out read 0 whenever out_valid=0. They are gated and never expose intermediate shares.
- Latency:
  - Accept at cycle 0 gives out_valid=1 at cycle 16*SBOX_LAT+1; with the default, cycle 65.
  - Throughput is one block per 16*SBOX_LAT+2 cycles when out_ready is held at 1.
- Boundary cases:
  - in_valid while in RUN or DONE is ignored.
  - rst asserted during RUN aborts with no partial output.
  - out_ready while not in DONE has no effect.
- Functional invariant: s0_out^s1_out = S8 applied bytewise to s0_in^s1_in.

Optional Feature:
SKINNY_SHARE_CLEAR_EN:
- When defined:
  - On the out handshake cycle, sh0_q, sh1_q and r_q are cleared to 0, so no share remanence is left in IDLE.
  - rnd_req also pulses on that cycle and r_q loads rnd, to refresh the S-box core's internal register inputs with random data.
  - That extra rnd_req does not count toward the 16.
- When undefined: the registers keep their last values in IDLE, and there are exactly 16 rnd_req pulses per block.
- Outputs stay gated to 0 in both cases.

Test Plan:
- Zero state: s0_in=0, s1_in=0, rnd random → s0_out^s1_out = 0x6565…65 (16 bytes).
- Masked all-ones: plaintext 0xFF…FF, s1_in=random M, s0_in=0xFF…FF^M → XOR of outputs = 0xFF…FF. Individual shares must not equal the unmasked value for non-zero M.
- Byte order: plaintext bytes 0x00,0x01,…,0x0F (MSB first), random mask → each output byte matches the LUT S8 at the same position (byte 0 = 0x65, byte 1 = 0x4C).
- Timing: in_valid pulse at cycle 0 with SBOX_LAT=4 → out_valid rises at cycle 65 and exactly 16 rnd_req pulses occur between cycles 0 and 60. in_ready=0 from cycle 1 until after the out handshake.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held at 1 → outputs stable and no new accept. out_ready=1 → IDLE next cycle, then accept on the following cycle.
- Reset mid-operation: rst at byte_cnt=7 → next cycle in IDLE, out_valid=0, outputs 0. A subsequent full block computes correctly.
